// File: rtl/sim_monitor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sim_monitor_pkg                                                          |
// | Shared FSM encodings and stop-reason codes for the simulation monitor.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package sim_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STOP    = 2'd1,
        ST_TIMEOUT = 2'd2
    } mon_state_e;

    localparam logic [1:0] RSN_NONE    = 2'b00;
    localparam logic [1:0] RSN_IDLE    = 2'b01;
    localparam logic [1:0] RSN_TIMEOUT = 2'b10;

    function automatic logic [1:0] state_reason(input mon_state_e s);
        logic [1:0] r;
        r = RSN_NONE;
        case (s)
            ST_STOP:    r = RSN_IDLE;
            ST_TIMEOUT: r = RSN_TIMEOUT;
            default:    r = RSN_NONE;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sim_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sim_sat_counter                                                          |
// | Up-counter that holds at MAX; clr has priority over en.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sim_sat_counter #(
    parameter int unsigned    W   = 8,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/sim_stop_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sim_stop_monitor                                                         |
// | Declares the simulated machine halted after a sustained idle stop state, |
// | or after a run-time watchdog expires.                                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sim_stop_monitor
    import sim_monitor_pkg::*;
#(
    parameter int unsigned STATE_W        = 3,
    parameter int unsigned STOP_STATE     = 0,
    parameter int unsigned N_ACT          = 2,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned IDLE_CYCLES    = 255,
    parameter int unsigned TMO_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter bit          STICKY         = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [STATE_W-1:0] pu_state,
    input  logic [N_ACT-1:0]   act,
    input  logic               clear,
    output logic               machine_is_stop,
    output logic [1:0]         stop_reason,
    output logic [CNT_W-1:0]   idle_count,
    output logic [TMO_W-1:0]   run_cycles
);

    localparam logic [CNT_W-1:0]   IDLE_MAX = CNT_W'(IDLE_CYCLES);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]   RUN_MAX  = '1;
    localparam logic [STATE_W-1:0] STOP_ENC = STATE_W'(STOP_STATE);
    localparam bit                 TMO_EN   = (TIMEOUT_CYCLES != 0);

    if ((IDLE_CYCLES < 1) || (64'(IDLE_CYCLES) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_idle
        $error("sim_stop_monitor: IDLE_CYCLES out of range for CNT_W");
    end
    if (N_ACT < 1) begin : g_bad_nact
        $error("sim_stop_monitor: N_ACT must be at least 1");
    end

    mon_state_e state_q;
    mon_state_e state_d;
    logic       idle_ok;
    logic       tmo_hit;
    logic       in_run;

    assign in_run = (state_q == ST_RUN);

    // Idle count is independent of the FSM so a non-sticky drop keeps its value.
    sim_sat_counter #(
        .W   (CNT_W),
        .MAX (IDLE_MAX)
    ) u_idle_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .en_i    (1'b1),
        .clr_i   (clear || (pu_state != STOP_ENC)),
        .count_o (idle_count)
    );

    sim_sat_counter #(
        .W   (TMO_W),
        .MAX (RUN_MAX)
    ) u_run_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .en_i    (in_run),
        .clr_i   (clear),
        .count_o (run_cycles)
    );

    assign idle_ok = (idle_count == IDLE_MAX) && (act == {N_ACT{1'b0}});
    assign tmo_hit = TMO_EN && (run_cycles == TMO_LAST) && in_run;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (idle_ok) begin
                        state_d = ST_STOP;
                    end else if (tmo_hit) begin
                        state_d = ST_TIMEOUT;
                    end
                end
                ST_STOP: begin
                    if (!STICKY && !idle_ok) begin
                        state_d = ST_RUN;
                    end
                end
                ST_TIMEOUT: state_d = ST_TIMEOUT;
                default:    state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign machine_is_stop = !in_run;
    assign stop_reason     = state_reason(state_q);

endmodule
`default_nettype wire

// File: tb/tb_sim_stop_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sim_stop_monitor                                                      |
// | Directed bench: sticky and non-sticky monitors against a reference model.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sim_stop_monitor;

    localparam int IDLE = 4;
    localparam int TMO  = 20;

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] pu_state;
    logic [1:0] act;
    logic       clear;

    logic        stop_o [2];
    logic [1:0]  rsn_o  [2];
    logic [7:0]  idle_o [2];
    logic [31:0] run_o  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Index 0 is sticky, index 1 is non-sticky.
    sim_stop_monitor #(
        .STATE_W(3), .STOP_STATE(0), .N_ACT(2), .CNT_W(8), .IDLE_CYCLES(IDLE),
        .TMO_W(32), .TIMEOUT_CYCLES(TMO), .STICKY(1'b1)
    ) u_dut_s1 (
        .clk(clk), .resetn(resetn), .pu_state(pu_state), .act(act), .clear(clear),
        .machine_is_stop(stop_o[0]), .stop_reason(rsn_o[0]),
        .idle_count(idle_o[0]), .run_cycles(run_o[0])
    );

    sim_stop_monitor #(
        .STATE_W(3), .STOP_STATE(0), .N_ACT(2), .CNT_W(8), .IDLE_CYCLES(IDLE),
        .TMO_W(32), .TIMEOUT_CYCLES(TMO), .STICKY(1'b0)
    ) u_dut_s0 (
        .clk(clk), .resetn(resetn), .pu_state(pu_state), .act(act), .clear(clear),
        .machine_is_stop(stop_o[1]), .stop_reason(rsn_o[1]),
        .idle_count(idle_o[1]), .run_cycles(run_o[1])
    );

    // Reference model: mode 0 = running, 1 = idle stop, 2 = watchdog stop.
    int          m_idle;
    int unsigned m_run  [2];
    int          m_mode [2];
    bit          m_valid = 1'b0;

    always @(posedge clk) begin : p_model
        bit ok;
        bit tmo;
        if (!resetn || clear) begin
            m_idle = 0;
            for (int i = 0; i < 2; i++) begin
                m_run[i]  = 0;
                m_mode[i] = 0;
            end
            if (!resetn) m_valid = 1'b1;
        end else if (m_valid) begin
            ok = (m_idle == IDLE) && (act == 2'b00);
            for (int i = 0; i < 2; i++) begin
                tmo = (m_run[i] == TMO - 1) && (m_mode[i] == 0);
                if (m_mode[i] == 0 && m_run[i] != 32'hFFFF_FFFF) m_run[i] = m_run[i] + 1;
                if (m_mode[i] == 0) begin
                    if (ok) m_mode[i] = 1;
                    else if (tmo) m_mode[i] = 2;
                end else if (m_mode[i] == 1) begin
                    if (i == 1 && !ok) m_mode[i] = 0;
                end
            end
            if (pu_state != 3'd0) m_idle = 0;
            else if (m_idle < IDLE) m_idle = m_idle + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model_stop[%0d]", i), 64'(stop_o[i]), 64'(m_mode[i] != 0));
                chk($sformatf("model_reason[%0d]", i), 64'(rsn_o[i]), 64'(m_mode[i]));
                chk($sformatf("model_idle[%0d]", i), 64'(idle_o[i]), 64'(m_idle));
                chk($sformatf("model_run[%0d]", i), 64'(run_o[i]), 64'(m_run[i]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input int i, input logic s, input logic [1:0] r,
                       input logic [7:0] id, input logic [31:0] rc);
        chk({nm, $sformatf("_stop[%0d]", i)}, 64'(stop_o[i]), 64'(s));
        chk({nm, $sformatf("_reason[%0d]", i)}, 64'(rsn_o[i]), 64'(r));
        chk({nm, $sformatf("_idle[%0d]", i)}, 64'(idle_o[i]), 64'(id));
        chk({nm, $sformatf("_run[%0d]", i)}, 64'(run_o[i]), 64'(rc));
    endtask

    task automatic lit2(input string nm, input logic s, input logic [1:0] r,
                        input logic [7:0] id, input logic [31:0] rc);
        lit(nm, 0, s, r, id, rc);
        lit(nm, 1, s, r, id, rc);
    endtask

    initial begin
        resetn   = 1'b0;
        pu_state = 3'd0;
        act      = 2'b00;
        clear    = 1'b0;
        step(2);
        lit2("reset", 1'b0, 2'b00, 8'd0, 32'd0);

        // Idle from reset release: stop exactly five edges later.
        resetn = 1'b1;
        step(4);
        lit2("idle_pre", 1'b0, 2'b00, 8'd4, 32'd4);
        step(1);
        lit2("idle_stop", 1'b1, 2'b01, 8'd4, 32'd5);

        // Leave the stop state: sticky holds, non-sticky drops one edge after idle_ok falls.
        pu_state = 3'd1;
        step(1);
        lit2("leave1", 1'b1, 2'b01, 8'd0, 32'd5);
        step(1);
        lit("sticky_hold", 0, 1'b1, 2'b01, 8'd0, 32'd5);
        lit("nonsticky_drop", 1, 1'b0, 2'b00, 8'd0, 32'd5);

        clear = 1'b1;
        step(1);
        lit2("clear", 1'b0, 2'b00, 8'd0, 32'd0);
        clear = 1'b0;

        // One-cycle excursion from the stop state restarts the idle count.
        pu_state = 3'd0;
        step(3);
        chk("restart_pre", 64'(idle_o[0]), 64'd3);
        pu_state = 3'd2;
        step(1);
        chk("restart_zero", 64'(idle_o[0]), 64'd0);
        pu_state = 3'd0;
        step(4);
        lit2("clr_race_pre", 1'b0, 2'b00, 8'd4, 32'd8);

        // Clear in the same cycle idle_ok is true wins.
        clear = 1'b1;
        step(1);
        lit2("clr_race", 1'b0, 2'b00, 8'd0, 32'd0);
        clear = 1'b0;

        // Activity while saturated delays stop without losing the count.
        step(2);
        act = 2'b01;
        step(5);
        lit2("act_hold", 1'b0, 2'b00, 8'd4, 32'd7);
        act = 2'b00;
        step(1);
        lit2("act_release", 1'b1, 2'b01, 8'd4, 32'd8);

        // Watchdog: busy forever ends in TIMEOUT after 20 run cycles.
        clear    = 1'b1;
        pu_state = 3'd1;
        step(1);
        clear = 1'b0;
        step(19);
        lit2("tmo_pre", 1'b0, 2'b00, 8'd0, 32'd19);
        step(1);
        lit2("tmo_hit", 1'b1, 2'b10, 8'd0, 32'd20);
        pu_state = 3'd0;
        step(6);
        lit2("tmo_frozen", 1'b1, 2'b10, 8'd4, 32'd20);

        // Reset for one cycle inside TIMEOUT, then rerun the basic idle stop.
        resetn = 1'b0;
        step(1);
        lit2("reset_tmo", 1'b0, 2'b00, 8'd0, 32'd0);
        resetn = 1'b1;
        step(5);
        lit2("rerun", 1'b1, 2'b01, 8'd4, 32'd5);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
